// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl
//   Write-side hazard controller for the ID/EX pipeline register. Each cycle
//   it decides whether ID/EX captures the decoded instruction, a bubble
//   (all control fields zeroed), or nothing new. It also steers the PC and
//   IF/ID registers. Load-use hazards (load in EX feeding the ID instruction)
//   stall fetch/decode. Taken branches resolved in EX flush IF/ID and bubble
//   ID/EX. A small FSM (RUN / LSTALL / FLUSH) stretches either action over
//   several cycles.
//
// Parameters
//   LOAD_STALL_CYCLES  bubble cycles per load-use hazard (1..15, 0 acts as 1)
//   FLUSH_CYCLES       cycles flush/bubble are held after a taken branch
//                      (1..15, 0 acts as 1)
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   Instruction_ID      ID instruction; rs=[25:21], rt=[20:16]
//   UsesRs_ID/UsesRt_ID ID instruction actually reads rs / rt
//   MemRead_EX          EX instruction is a load
//   RegWrite_EX         EX instruction writes the register file
//   WriteRegAddress_EX  EX destination register
//   BranchTaken_EX      branch resolved taken in EX
//   PCWrite             PC update enable
//   IFIDWrite           IF/ID load enable
//   IFIDFlush           IF/ID loads a NOP
//   IDEXBubble          ID/EX loads zeroed control fields
//   Stalled             FSM is in LSTALL or FLUSH
//
// Optional build macro HAZARD_PERF_CNT_EN adds two saturating 32-bit
// counters: StallCycles (bubble without flush) and FlushCycles (flush
// cycles outside reset).

module id_ex_hazard_ctrl #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Instruction_ID,
   input  logic        UsesRs_ID,
   input  logic        UsesRt_ID,
   input  logic        MemRead_EX,
   input  logic        RegWrite_EX,
   input  logic [4:0]  WriteRegAddress_EX,
   input  logic        BranchTaken_EX,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        IFIDFlush,
   output logic        IDEXBubble,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0] StallCycles,
   output logic [31:0] FlushCycles,
`endif
   output logic        Stalled
);

   // Clamp parameters into the range the 4-bit counter can hold; 0 acts as 1.
   localparam int LS_EFF = (LOAD_STALL_CYCLES < 1) ? 1 :
                           (LOAD_STALL_CYCLES > 15) ? 15 : LOAD_STALL_CYCLES;
   localparam int FL_EFF = (FLUSH_CYCLES < 1) ? 1 :
                           (FLUSH_CYCLES > 15) ? 15 : FLUSH_CYCLES;
   localparam logic [3:0] LS_RELOAD = 4'(LS_EFF - 1);
   localparam logic [3:0] FL_RELOAD = 4'(FL_EFF - 1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      LSTALL = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic [4:0] rs_id;
   logic [4:0] rt_id;
   logic       hz;
   logic       br;
   logic       unused_instr;

   assign rs_id = Instruction_ID[25:21];
   assign rt_id = Instruction_ID[20:16];
   assign unused_instr = ^{Instruction_ID[31:26], Instruction_ID[15:0]};

   // $0 is hard-wired zero, so a load targeting it can never feed ID.
   assign hz = MemRead_EX & RegWrite_EX & (WriteRegAddress_EX != 5'd0) &
               ((UsesRs_ID & (WriteRegAddress_EX == rs_id)) |
                (UsesRt_ID & (WriteRegAddress_EX == rt_id)));
   assign br = BranchTaken_EX;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IFIDFlush  = 1'b0;
      IDEXBubble = 1'b0;

      // A taken branch wins in every state; it redirects fetch, squashes
      // IF/ID and bubbles ID/EX, and (re)starts the flush window.
      if (br) begin
         IFIDFlush  = 1'b1;
         IDEXBubble = 1'b1;
         if (FL_EFF > 1) begin
            state_d = FLUSH;
            cnt_d   = FL_RELOAD;
         end else begin
            state_d = RUN;
            cnt_d   = 4'd0;
         end
      end else begin
         unique case (state_q)
            RUN: begin
               if (hz) begin
                  PCWrite    = 1'b0;
                  IFIDWrite  = 1'b0;
                  IDEXBubble = 1'b1;
                  if (LS_EFF > 1) begin
                     state_d = LSTALL;
                     cnt_d   = LS_RELOAD;
                  end
               end
            end
            // EX holds a bubble here, so hz is not re-evaluated.
            LSTALL: begin
               PCWrite    = 1'b0;
               IFIDWrite  = 1'b0;
               IDEXBubble = 1'b1;
               cnt_d      = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = RUN;
            end
            // Fetch continues normally; the wrong-path slots are squashed.
            FLUSH: begin
               IFIDFlush  = 1'b1;
               IDEXBubble = 1'b1;
               cnt_d      = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = RUN;
            end
            default: begin
               state_d = RUN;
               cnt_d   = 4'd0;
            end
         endcase
      end

      // Reset drives the pipeline to a safe bubble immediately, not at an edge.
      if (rst) begin
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IFIDFlush  = 1'b1;
         IDEXBubble = 1'b1;
      end
   end

   assign Stalled = (state_q == LSTALL) || (state_q == FLUSH);

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_cycles_q, flush_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_cycles_d = flush_cycles_q;
      if (IDEXBubble && !IFIDFlush && (stall_cycles_q != 32'hFFFF_FFFF))
         stall_cycles_d = stall_cycles_q + 32'd1;
      if (IFIDFlush && !rst && (flush_cycles_q != 32'hFFFF_FFFF))
         flush_cycles_d = flush_cycles_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= 32'd0;
         flush_cycles_q <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_cycles_q <= flush_cycles_d;
      end
   end

   assign StallCycles = stall_cycles_q;
   assign FlushCycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed testbench for id_ex_hazard_ctrl. Three instances share stimulus:
//   u_dut_def : defaults (LOAD_STALL_CYCLES=1, FLUSH_CYCLES=1)
//   u_dut_cfg : LOAD_STALL_CYCLES=3, FLUSH_CYCLES=2
//   u_dut_abt : LOAD_STALL_CYCLES=4, FLUSH_CYCLES=1
// Outputs are compared as {PCWrite,IFIDWrite,IFIDFlush,IDEXBubble,Stalled}.

module tb_id_ex_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        uses_rs, uses_rt, mem_rd, reg_wr, br_taken;
   logic [4:0]  wr_addr;

   logic pc_def, ifw_def, fl_def, bub_def, st_def;
   logic pc_cfg, ifw_cfg, fl_cfg, bub_cfg, st_cfg;
   logic pc_abt, ifw_abt, fl_abt, bub_abt, st_abt;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] sc_def, fc_def, sc_cfg, fc_cfg, sc_abt, fc_abt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc_no = 0;

   always #5 clk = ~clk;

   id_ex_hazard_ctrl u_dut_def (
      .clk(clk), .rst(rst), .Instruction_ID(instr),
      .UsesRs_ID(uses_rs), .UsesRt_ID(uses_rt),
      .MemRead_EX(mem_rd), .RegWrite_EX(reg_wr),
      .WriteRegAddress_EX(wr_addr), .BranchTaken_EX(br_taken),
      .PCWrite(pc_def), .IFIDWrite(ifw_def), .IFIDFlush(fl_def),
      .IDEXBubble(bub_def),
`ifdef HAZARD_PERF_CNT_EN
      .StallCycles(sc_def), .FlushCycles(fc_def),
`endif
      .Stalled(st_def)
   );

   id_ex_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) u_dut_cfg (
      .clk(clk), .rst(rst), .Instruction_ID(instr),
      .UsesRs_ID(uses_rs), .UsesRt_ID(uses_rt),
      .MemRead_EX(mem_rd), .RegWrite_EX(reg_wr),
      .WriteRegAddress_EX(wr_addr), .BranchTaken_EX(br_taken),
      .PCWrite(pc_cfg), .IFIDWrite(ifw_cfg), .IFIDFlush(fl_cfg),
      .IDEXBubble(bub_cfg),
`ifdef HAZARD_PERF_CNT_EN
      .StallCycles(sc_cfg), .FlushCycles(fc_cfg),
`endif
      .Stalled(st_cfg)
   );

   id_ex_hazard_ctrl #(.LOAD_STALL_CYCLES(4), .FLUSH_CYCLES(1)) u_dut_abt (
      .clk(clk), .rst(rst), .Instruction_ID(instr),
      .UsesRs_ID(uses_rs), .UsesRt_ID(uses_rt),
      .MemRead_EX(mem_rd), .RegWrite_EX(reg_wr),
      .WriteRegAddress_EX(wr_addr), .BranchTaken_EX(br_taken),
      .PCWrite(pc_abt), .IFIDWrite(ifw_abt), .IFIDFlush(fl_abt),
      .IDEXBubble(bub_abt),
`ifdef HAZARD_PERF_CNT_EN
      .StallCycles(sc_abt), .FlushCycles(fc_abt),
`endif
      .Stalled(st_abt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic mr, input logic rw, input logic [4:0] wa,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic br);
      mem_rd   = mr;
      reg_wr   = rw;
      wr_addr  = wa;
      instr    = {6'h23, rs, rt, 16'hBEEF};
      uses_rs  = urs;
      uses_rt  = urt;
      br_taken = br;
   endtask

   task automatic check_all(input string tag, input logic [4:0] e_def,
                            input logic [4:0] e_cfg, input logic [4:0] e_abt);
      check({tag, "/def"}, {27'd0, pc_def, ifw_def, fl_def, bub_def, st_def}, {27'd0, e_def});
      check({tag, "/cfg"}, {27'd0, pc_cfg, ifw_cfg, fl_cfg, bub_cfg, st_cfg}, {27'd0, e_cfg});
      check({tag, "/abt"}, {27'd0, pc_abt, ifw_abt, fl_abt, bub_abt, st_abt}, {27'd0, e_abt});
   endtask

   // One pipeline cycle: inputs already applied, sample at negedge,
   // then advance past the next rising edge.
   task automatic cyc(input string tag, input logic [4:0] e_def,
                      input logic [4:0] e_cfg, input logic [4:0] e_abt);
      @(negedge clk);
      check_all(tag, e_def, e_cfg, e_abt);
      $display("cycle %0d %s: def=%b cfg=%b abt=%b", cyc_no, tag,
               {pc_def, ifw_def, fl_def, bub_def, st_def},
               {pc_cfg, ifw_cfg, fl_cfg, bub_cfg, st_cfg},
               {pc_abt, ifw_abt, fl_abt, bub_abt, st_abt});
      cyc_no++;
      @(posedge clk);
      #1;
   endtask

   localparam logic [4:0] O_RUN = 5'b11000;
   localparam logic [4:0] O_HZ  = 5'b00010;
   localparam logic [4:0] O_LS  = 5'b00011;
   localparam logic [4:0] O_BR  = 5'b11110;
   localparam logic [4:0] O_BRS = 5'b11111;
   localparam logic [4:0] O_RST = 5'b00110;

   initial begin
      rst = 1'b1;
      set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      @(negedge clk);
      check_all("reset", O_RST, O_RST, O_RST);
      @(posedge clk);
      #1 rst = 1'b0;

      set_in(0, 0, 5'd0, 5'd1, 5'd2, 1, 1, 0);
      cyc("idle", O_RUN, O_RUN, O_RUN);

      // Load-use on rt
      set_in(1, 1, 5'd5, 5'd1, 5'd5, 1, 1, 0);
      cyc("lu_rt", O_HZ, O_HZ, O_HZ);
      set_in(0, 0, 5'd0, 5'd1, 5'd2, 1, 1, 0);
      cyc("lu_rt+1", O_RUN, O_LS, O_LS);
      cyc("lu_rt+2", O_RUN, O_LS, O_LS);
      cyc("lu_rt+3", O_RUN, O_RUN, O_LS);

      // Load-use on rs
      set_in(1, 1, 5'd8, 5'd8, 5'd3, 1, 0, 0);
      cyc("lu_rs", O_HZ, O_HZ, O_HZ);
      set_in(0, 0, 5'd0, 5'd1, 5'd2, 1, 1, 0);
      cyc("lu_rs+1", O_RUN, O_LS, O_LS);
      cyc("lu_rs+2", O_RUN, O_LS, O_LS);
      cyc("lu_rs+3", O_RUN, O_RUN, O_LS);

      // $0 destination and unused operand never stall
      set_in(1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0);
      cyc("reg0", O_RUN, O_RUN, O_RUN);
      set_in(1, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0);
      cyc("unused_rt", O_RUN, O_RUN, O_RUN);

      // Branch beats load in the same cycle
      set_in(1, 1, 5'd5, 5'd1, 5'd5, 1, 1, 1);
      cyc("br_hz", O_BR, O_BR, O_BR);
      set_in(0, 0, 5'd0, 5'd1, 5'd2, 1, 1, 0);
      cyc("br_hz+1", O_RUN, O_BRS, O_RUN);
      cyc("br_hz+2", O_RUN, O_RUN, O_RUN);

      // Branch in the 2nd stall cycle aborts the stall
      set_in(1, 1, 5'd5, 5'd1, 5'd5, 1, 1, 0);
      cyc("abort_hz", O_HZ, O_HZ, O_HZ);
      set_in(0, 0, 5'd0, 5'd1, 5'd2, 1, 1, 1);
      cyc("abort_br", O_BR, O_BRS, O_BRS);
      set_in(0, 0, 5'd0, 5'd1, 5'd2, 1, 1, 0);
      cyc("abort+1", O_RUN, O_BRS, O_RUN);
      cyc("abort+2", O_RUN, O_RUN, O_RUN);

      // Asynchronous reset in the middle of a stall
      set_in(1, 1, 5'd5, 5'd1, 5'd5, 1, 1, 0);
      cyc("pre_rst_hz", O_HZ, O_HZ, O_HZ);
      set_in(0, 0, 5'd0, 5'd1, 5'd2, 1, 1, 0);
      cyc("pre_rst_ls", O_RUN, O_LS, O_LS);
      #2 rst = 1'b1;
      #1;
      check_all("async_rst", O_RST, O_RST, O_RST);
      $display("async reset mid-stall: def=%b cfg=%b abt=%b",
               {pc_def, ifw_def, fl_def, bub_def, st_def},
               {pc_cfg, ifw_cfg, fl_cfg, bub_cfg, st_cfg},
               {pc_abt, ifw_abt, fl_abt, bub_abt, st_abt});
      @(posedge clk);
      #1 rst = 1'b0;
      cyc("post_rst", O_RUN, O_RUN, O_RUN);

      // Abort sequence from clean counters
      set_in(1, 1, 5'd5, 5'd1, 5'd5, 1, 1, 0);
      cyc("perf_hz", O_HZ, O_HZ, O_HZ);
      set_in(0, 0, 5'd0, 5'd1, 5'd2, 1, 1, 1);
      cyc("perf_br", O_BR, O_BRS, O_BRS);
      set_in(0, 0, 5'd0, 5'd1, 5'd2, 1, 1, 0);
      @(negedge clk);
      check_all("perf_end", O_RUN, O_BRS, O_RUN);
`ifdef HAZARD_PERF_CNT_EN
      check("stall_cycles_abt", sc_abt, 32'd1);
      check("flush_cycles_abt", fc_abt, 32'd1);
      check("stall_cycles_def", sc_def, 32'd1);
      check("flush_cycles_def", fc_def, 32'd1);
      $display("perf counters: abt stall=%0d flush=%0d", sc_abt, fc_abt);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_hazard_ctrl.md
Name: id_ex_hazard_ctrl

Overview:
- Hazard controller on the write side of the ID/EX pipeline register; decides each cycle whether ID/EX captures the decoded instruction, a bubble, or nothing new.
- Detects load-use hazards between the load in EX and the instruction in ID, and taken branches resolved in EX.
- Drives the PC write enable, the IF/ID write enable and flush, and the ID/EX bubble select, which zeroes all control fields entering ID/EX.
- A small FSM handles multi-cycle load stalls and multi-cycle branch flushes.

Parameters:
- LOAD_STALL_CYCLES, 1, number of bubble cycles inserted per load-use hazard (1..15).
- FLUSH_CYCLES, 1, number of cycles IF/ID flush and ID/EX bubble are held after a taken branch (1..15).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- Instruction_ID  input  32  instruction in ID; rs=[25:21], rt=[20:16].
- UsesRs_ID  input  1  ID instruction reads rs.
- UsesRt_ID  input  1  ID instruction reads rt.
- MemRead_EX  input  1  instruction in EX is a load.
- RegWrite_EX  input  1  instruction in EX writes the register file.
- WriteRegAddress_EX  input  5  destination register of the EX instruction.
- BranchTaken_EX  input  1  branch resolved taken in EX this cycle.
- PCWrite  output  1  PC update enable.
- IFIDWrite  output  1  IF/ID load enable.
- IFIDFlush  output  1  IF/ID loads a NOP.
- IDEXBubble  output  1  ID/EX loads zeroed control fields.
- Stalled  output  1  FSM is not in RUN.

Behaviour:
- Reset: clk, rst single clock, asynchronous active-high reset (fixed).
- While rst=1: state=RUN, cnt=0, PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1, Stalled=0.
- After rst deasserts, outputs follow the rules below from the next evaluation.
- Hazard definitions:
  - hz = MemRead_EX & RegWrite_EX & (WriteRegAddress_EX!=0) & ((UsesRs_ID & WriteRegAddress_EX==rs) | (UsesRt_ID & WriteRegAddress_EX==rt)).
  - br = BranchTaken_EX.
- Outputs are Mealy: they respond in the same cycle the hazard is visible. Zero added latency.
- State RUN:
  - br=1: PCWrite=1 (PC loads the branch target), IFIDWrite=1, IFIDFlush=1, IDEXBubble=1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Else hz=1: PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXBubble=1. If LOAD_STALL_CYCLES>1, go to LSTALL with cnt=LOAD_STALL_CYCLES-1; otherwise stay in RUN.
  - Else: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
- State LSTALL:
  - Outputs as for hz in RUN; cnt decrements each cycle; when cnt==1, next state is RUN.
  - hz is not re-evaluated here, because EX holds a bubble.
  - br=1 in LSTALL aborts the stall and is handled exactly as br in RUN, including the FLUSH entry.
- State FLUSH:
  - Outputs as for br in RUN, except PCWrite=1 continues normal fetch.
  - cnt decrements each cycle; when cnt==1, next state is RUN.
  - hz is ignored in FLUSH. A new br=1 reloads cnt=FLUSH_CYCLES-1.
- Priority: br over hz in every state.
- Stalled=1 exactly when state is LSTALL or FLUSH.
- cnt is 4 bits.
- Parameter value 0 is illegal; treat it as 1.
- Register $0 never causes a hazard.
- rst asserted mid-stall or mid-flush returns immediately to RUN and the reset output values.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds two outputs: StallCycles (32) and FlushCycles (32).
  - StallCycles increments on every clk where IDEXBubble=1 and IFIDFlush=0.
  - FlushCycles increments on every clk where IFIDFlush=1 and rst=0.
  - Both counters clear on rst and saturate at 32'hFFFFFFFF.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset: rst=1 mid-run → PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1 immediately, without a clk edge; after release with no hazard → 1,1,0,0.
- Load-use on rt, defaults: MemRead_EX=1, RegWrite_EX=1, WriteRegAddress_EX=5, ID rt=5, UsesRt_ID=1 → exactly one cycle with PCWrite=0, IFIDWrite=0, IDEXBubble=1; Stalled stays 0.
- Multi-cycle stall, LOAD_STALL_CYCLES=3, dest=8=rs, UsesRs_ID=1 → 3 consecutive bubble cycles, Stalled=1 for cycles 2-3, then RUN.
- $0 and unused operand: WriteRegAddress_EX=0 matching rs, or a match on rt with UsesRt_ID=0 → no stall.
- Branch beats load: br=1 and hz=1 in the same cycle → IFIDFlush=1, IDEXBubble=1, PCWrite=1. With FLUSH_CYCLES=2 → flush held 2 cycles, then RUN.
- Branch aborts stall, LOAD_STALL_CYCLES=4: br=1 in the 2nd stall cycle → PCWrite=1 and IFIDFlush=1 that cycle, LSTALL exits. With HAZARD_PERF_CNT_EN defined → StallCycles=1, FlushCycles=1.
